// File: rtl/fifo_rr_drain_ctrl.sv
// Round-robin drain scheduler: grants one non-empty source FIFO at a time for a
// burst of up to BURST_LEN reads and forwards each word to a single output register.
//
// state | meaning
// IDLE  | no reads; pick the next non-empty source at or after rr_ptr
// BURST | reading from grant while out_ready credits arrive
module fifo_rr_drain_ctrl #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 8,
    localparam int WORD_W    = DATA_WIDTH * 3,
    localparam int SRC_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    localparam int CNT_W     = $clog2(BURST_LEN + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_SRC-1:0]          src_empty,
    output logic [NUM_SRC-1:0]          src_rd_req,
    input  logic [NUM_SRC*WORD_W-1:0]   src_data,
    input  logic                        out_ready,
    output logic                        out_valid,
    output logic [WORD_W-1:0]           out_data,
    output logic [SRC_W-1:0]            out_src,
    output logic                        busy,
    output logic                        burst_done
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

    state_t             state;
    logic [SRC_W-1:0]   rr_ptr;
    logic [SRC_W-1:0]   grant;
    logic [CNT_W-1:0]   count;
    logic [SRC_W-1:0]   pick;
    logic               pick_valid;
    logic               grant_empty;
    logic               issue;
    logic [WORD_W-1:0]  grant_data;

    // Modular add without assuming NUM_SRC is a power of two.
    function automatic logic [SRC_W-1:0] wrap_add(input logic [SRC_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_SRC)
            s = s - NUM_SRC;
        return SRC_W'(s);
    endfunction

    // Scan downward so the smallest offset from rr_ptr is the one that sticks.
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (!src_empty[wrap_add(rr_ptr, i)]) begin
                pick_valid = 1'b1;
                pick       = wrap_add(rr_ptr, i);
            end
        end
    end

    assign grant_empty = src_empty[grant];
    assign grant_data  = src_data[grant*WORD_W +: WORD_W];
    assign issue       = (state == BURST) && out_ready && !grant_empty && !rst;

    always_comb begin
        src_rd_req = '0;
        if (issue)
            src_rd_req[grant] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            grant      <= '0;
            count      <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_src    <= '0;
            burst_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            burst_done <= 1'b0;
            out_valid  <= issue;
            if (issue) begin
                out_data <= grant_data;
                out_src  <= grant;
            end

            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant <= pick;
                        count <= '0;
                        state <= BURST;
                        busy  <= 1'b1;
                    end
                end
                BURST: begin
                    // A final read that also empties the source counts as one exit.
                    if ((issue && count == LAST_CNT) || grant_empty) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        rr_ptr     <= wrap_add(grant, 1);
                        burst_done <= 1'b1;
                    end else if (issue) begin
                        count <= count + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rr_drain_ctrl.sv
// Scoreboard bench for fifo_rr_drain_ctrl: a queue-based FIFO model feeds the DUT,
// directed tests push expected words/checks, and a negedge monitor compares them.
module tb_fifo_rr_drain_ctrl;
    localparam int NS = 4;
    localparam int DW = 32;
    localparam int BL = 8;
    localparam int WW = DW * 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [NS-1:0]     src_empty;
    logic [NS-1:0]     src_rd_req;
    logic [NS*WW-1:0]  src_data;
    logic              out_ready;
    logic              out_valid;
    logic [WW-1:0]     out_data;
    logic [1:0]        out_src;
    logic              busy;
    logic              burst_done;

    fifo_rr_drain_ctrl #(.NUM_SRC(NS), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .clk(clk), .rst(rst), .src_empty(src_empty), .src_rd_req(src_rd_req),
        .src_data(src_data), .out_ready(out_ready), .out_valid(out_valid),
        .out_data(out_data), .out_src(out_src), .busy(busy), .burst_done(burst_done)
    );

    always #5 clk = ~clk;

    typedef struct { logic [WW-1:0] data; logic [1:0] src; } exp_t;
    typedef struct { string name; logic [127:0] got; logic [127:0] exp; } chk_t;

    exp_t          exp_q[$];
    chk_t          chk_q[$];
    logic [WW-1:0] fq[NS][$];
    int            n_checks = 0;
    int            n_errors = 0;
    int            bd_cnt   = 0;
    logic [NS-1:0] req_s;
    logic          busy_s;
    logic          ov_s;
    chk_t          mc;
    exp_t          me;

    function automatic logic [WW-1:0] mk_word(input int base, input int k);
        logic [31:0] v;
        v = 32'(base + k);
        return {v ^ 32'hA5A5_0000, v ^ 32'h5A00_0000, v};
    endfunction

    function automatic int fq_total();
        int t = 0;
        for (int i = 0; i < NS; i++) t += fq[i].size();
        return t;
    endfunction

    task automatic push_chk(input string n, input logic [127:0] g, input logic [127:0] e);
        chk_t c;
        c.name = n; c.got = g; c.exp = e;
        chk_q.push_back(c);
    endtask

    task automatic refresh();
        for (int i = 0; i < NS; i++) begin
            src_empty[i] = (fq[i].size() == 0);
            src_data[i*WW +: WW] = (fq[i].size() == 0) ? '0 : fq[i][0];
        end
    endtask

    task automatic load(input int s, input int n, input int base);
        for (int k = 0; k < n; k++) fq[s].push_back(mk_word(base, k));
        refresh();
    endtask

    task automatic expect_words(input int s, input int n, input int base);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.data = mk_word(base, k);
            e.src  = 2'(s);
            exp_q.push_back(e);
        end
    endtask

    // One clock: sample at negedge, pop the FIFOs that were read, update inputs after the edge.
    task automatic tick();
        @(negedge clk);
        req_s  = src_rd_req;
        busy_s = busy;
        ov_s   = out_valid;
        @(posedge clk);
        #1;
        for (int i = 0; i < NS; i++)
            if (req_s[i] === 1'b1 && fq[i].size() > 0) void'(fq[i].pop_front());
        refresh();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        for (int i = 0; i < NS; i++) fq[i].delete();
        refresh();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain(input string n, input int bound);
        for (int t = 0; t < bound; t++) begin
            if (fq_total() == 0 && exp_q.size() == 0) break;
            tick();
        end
        repeat (3) tick();
        push_chk(n, 128'(fq_total() + exp_q.size()), 0);
    endtask

    always @(negedge clk) begin
        while (chk_q.size() > 0) begin
            mc = chk_q.pop_front();
            n_checks++;
            if (mc.got !== mc.exp) begin
                n_errors++;
                $display("FAIL %s: got %0h expected %0h", mc.name, mc.got, mc.exp);
            end
        end
        if (burst_done === 1'b1) bd_cnt++;
        if (rst === 1'b0) begin
            n_checks++;
            if (!$onehot0(src_rd_req)) begin
                n_errors++;
                $display("FAIL rd_req_onehot: got %b expected one-hot or zero", src_rd_req);
            end
        end
        if (out_valid === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_out: got data %0h src %0d expected no word", out_data, out_src);
            end else begin
                me = exp_q.pop_front();
                if (out_data !== me.data || out_src !== me.src) begin
                    n_errors++;
                    $display("FAIL out_word: got data %0h src %0d expected data %0h src %0d",
                             out_data, out_src, me.data, me.src);
                end
            end
        end
    end

    int bd0;
    int reads;
    int idles;
    int cnt3;
    int guard;
    int pat4[11] = '{0, 2, 2, 2, 0, 0, 4, 4, 4, 4, 4};

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        src_empty = '1;
        src_data = '0;
        tick();
        tick();
        push_chk("reset_state", {src_rd_req, out_valid, busy, burst_done, out_src, out_data}, 0);
        rst = 1'b0;

        // All sources empty: fully quiet.
        apply_reset();
        out_ready = 1'b1;
        for (int t = 0; t < 20; t++) begin
            tick();
            push_chk("t1_quiet", {req_s, busy_s, ov_s}, 0);
        end

        // Single source, repeated bursts with one bubble each.
        apply_reset();
        bd0 = bd_cnt;
        load(2, 20, 'h100);
        expect_words(2, 20, 'h100);
        for (int t = 0; t < 19; t++) begin
            tick();
            push_chk("t2_rd_pat", req_s, (t % 9 != 0) ? 4'b0100 : 4'b0000);
            push_chk("t2_busy", busy_s, (t % 9 != 0));
        end
        drain("t2_drain", 40);
        push_chk("t2_bursts", bd_cnt - bd0, 3);
        push_chk("t2_idle_busy", busy_s, 0);

        // All four sources: rotation 0,1,2,3 twice, 9 cycles per burst.
        apply_reset();
        bd0 = bd_cnt;
        for (int s = 0; s < NS; s++) load(s, 16, 'h1000 + s * 'h100);
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < NS; s++) expect_words(s, 8, 'h1000 + s * 'h100 + r * 8);
        reads = 0;
        idles = 0;
        for (int t = 0; t < 72; t++) begin
            tick();
            if (req_s != 0) reads++; else idles++;
        end
        push_chk("t3_reads_72cyc", reads, 64);
        push_chk("t3_idles_72cyc", idles, 8);
        drain("t3_drain", 10);
        push_chk("t3_bursts", bd_cnt - bd0, 8);

        // Short source exits on empty, next grant moves on.
        apply_reset();
        bd0 = bd_cnt;
        load(1, 3, 'h2100);
        load(2, 5, 'h2200);
        expect_words(1, 3, 'h2100);
        expect_words(2, 5, 'h2200);
        for (int t = 0; t < 11; t++) begin
            tick();
            push_chk("t4_rd_pat", req_s, 4'(pat4[t]));
        end
        drain("t4_drain", 20);
        push_chk("t4_bursts", bd_cnt - bd0, 2);

        // Backpressure pattern 1,0,0,1 stalls issue but keeps bursts at 8 words.
        apply_reset();
        bd0 = bd_cnt;
        load(0, 16, 'h3000);
        load(1, 8, 'h3100);
        expect_words(0, 8, 'h3000);
        expect_words(1, 8, 'h3100);
        expect_words(0, 8, 'h3008);
        for (int t = 0; t < 200; t++) begin
            if (fq_total() == 0 && exp_q.size() == 0) break;
            out_ready = (t % 4 == 0) || (t % 4 == 3);
            tick();
            if (!out_ready) push_chk("t5_stall_noreq", req_s, 0);
        end
        out_ready = 1'b1;
        drain("t5_drain", 10);
        push_chk("t5_bursts", bd_cnt - bd0, 3);

        // Reset on the 4th read of a src-3 burst; rr_ptr must restart at 0.
        apply_reset();
        bd0 = bd_cnt;
        load(2, 8, 'h4200);
        load(3, 16, 'h4300);
        expect_words(2, 8, 'h4200);
        expect_words(3, 3, 'h4300);
        cnt3 = 0;
        guard = 0;
        while (cnt3 < 3 && guard < 40) begin
            tick();
            if (req_s[3] === 1'b1) cnt3++;
            guard++;
        end
        push_chk("t6_reach_3rd_read", cnt3, 3);
        rst = 1'b1;
        #1;
        push_chk("t6_rst_noreq", src_rd_req, 0);
        tick();
        rst = 1'b0;
        push_chk("t6_ov_after_rst", out_valid, 0);
        push_chk("t6_busy_after_rst", busy, 0);
        push_chk("t6_bursts_before_rst", bd_cnt - bd0, 1);
        bd0 = bd_cnt;
        load(1, 4, 'h4100);
        expect_words(1, 4, 'h4100);
        expect_words(3, 13, 'h4303);
        drain("t6_drain", 60);
        push_chk("t6_bursts_after_rst", bd_cnt - bd0, 3);

        push_chk("exp_q_empty", exp_q.size(), 0);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fifo_rr_drain_ctrl.md
Name: fifo_rr_drain_ctrl

Overview:
- Round-robin read scheduler that drains NUM_SRC feature-map FIFOs into one shared convolution-engine input port.
- Each FIFO entry is a 3-lane word (DATA_WIDTH*3 bits).
- Grants one source at a time for a burst of up to BURST_LEN reads.
- Sits between the per-channel FIFO bank and the PE array input register.

Parameters:
- NUM_SRC, 4, number of source FIFOs (>=2).
- DATA_WIDTH, 32, width of one lane; each word is DATA_WIDTH*3 bits.
- BURST_LEN, 8, maximum reads per grant (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- src_empty  input  NUM_SRC  per-source FIFO empty flag.
- src_rd_req  output  NUM_SRC  per-source read request, one-hot or zero.
- src_data  input  NUM_SRC*DATA_WIDTH*3  packed FIFO outputs; source i occupies bits [(i+1)*DATA_WIDTH*3-1 : i*DATA_WIDTH*3].
- out_ready  input  1  downstream can take a word one cycle from now.
- out_valid  output  1  out_data/out_src valid this cycle.
- out_data  output  DATA_WIDTH*3  registered word.
- out_src  output  max(1,$clog2(NUM_SRC))  source index of out_data.
- busy  output  1  high while in BURST.
- burst_done  output  1  one-cycle pulse after a burst ends.

Behaviour:
- Clocking and reset: single clock domain. Reset is synchronous and active-high; all registers change only on posedge clk.
- Reset values: state=IDLE, rr_ptr=0, grant=0, count=0, out_valid=0, out_data=0, out_src=0, burst_done=0, busy=0. src_rd_req is forced to 0 while rst is high.
- State machine: two states, IDLE and BURST.
- IDLE:
  - No reads issued.
  - If any src_empty is low, pick the first non-empty source searching upward from rr_ptr with wrap.
  - Register the choice as grant, clear count, go to BURST.
  - This costs exactly one arbitration bubble cycle per burst.
- BURST, read issue:
  - src_rd_req[grant] = out_ready & ~src_empty[grant] & ~rst (combinational). All other bits are 0.
  - Each issued read increments count.
- BURST, exit: at the clock edge where either of the following holds:
  - (a) a read issues with count==BURST_LEN-1, or
  - (b) src_empty[grant] is high.
- On exit:
  - rr_ptr <= (grant+1) mod NUM_SRC.
  - State goes to IDLE.
  - burst_done is high the following cycle for exactly 1 cycle.
- Backpressure: out_ready low stalls issue without ending the burst. count is held and the grant is held.
- Data capture:
  - src_data for source g is valid in the same cycle src_rd_req[g] is high.
  - On that edge, the block registers the slice into out_data, sets out_src=grant and out_valid=1.
  - out_valid=0 on any cycle following a non-issue cycle. Read-to-out_valid latency is 1 cycle.
  - out_data holds its last value when out_valid=0.
  - Downstream must accept every out_valid cycle; out_ready is the advance credit.
- busy: equals (state==BURST).
- Fairness: a source continuously non-empty is granted at least once every NUM_SRC bursts.
- Simultaneous events:
  - A source going empty in the same cycle as its final read: condition (a) applies and exit happens once; burst_done pulses once.
  - Other sources changing empty state mid-burst has no effect until the next IDLE.
- Reset mid-burst:
  - The burst is abandoned immediately.
  - No rd_req is issued in the reset cycle.
  - out_valid is 0 the cycle after reset, even if a read was issued the cycle before.
  - rr_ptr returns to 0.
- Counter widths: count is $clog2(BURST_LEN+1) bits; rr_ptr and grant are out_src width. Modular wrap is explicit (no reliance on power-of-2 NUM_SRC).

Test Plan:
- Reset then all src_empty=1 for 20 cycles -> src_rd_req=0, out_valid=0, busy=0 throughout.
- Only src 2 non-empty with 20 entries (data 0x100+k), out_ready=1 -> 1 IDLE bubble, then 8 consecutive reads of src 2; out_valid follows 1 cycle later with 0x100..0x107 and out_src=2; burst_done pulses; after one bubble the next burst starts on src 2 again.
- All 4 sources holding 16 entries each, out_ready=1 -> grant order 0,1,2,3,0,1,2,3; each burst is 8 words; 9 cycles per burst including the bubble.
- Src 1 holding 3 entries, BURST_LEN=8 -> 3 reads, exit on empty, burst_done pulse, next grant goes to src 2 if non-empty.
- out_ready toggling 1,0,0,1,... during a burst -> rd_req only on ready cycles; count and grant held; still exactly 8 words per burst, in order.
- rst asserted for 1 cycle on the 4th read of a burst from src 3 -> no rd_req in the reset cycle; out_valid=0 next cycle; the next grant scans from src 0.
